// File: rtl/csa_seq_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// csa_seq_adder_ctrl_if
// Purpose : Bundles the operand request handshake, the result handshake and
//           the status flag of the sequential carry-select adder controller.
// Signals :
//   in_valid  (master->slave)  operand request
//   in_ready  (slave->master)  controller can accept operands
//   a_in/b_in (master->slave)  WIDTH-bit operands
//   c_in      (master->slave)  carry-in to slice 0
//   out_valid (slave->master)  result available
//   out_ready (master->slave)  consumer accepts result
//   sum_out   (slave->master)  WIDTH-bit sum
//   carry_out (slave->master)  carry from the top slice
//   busy_out  (slave->master)  an operation is in flight or awaiting pickup
// -----------------------------------------------------------------------------
interface csa_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             busy_out;

    modport master (
        output in_valid, a_in, b_in, c_in, out_ready,
        input  in_ready, out_valid, sum_out, carry_out, busy_out
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, out_ready,
        output in_ready, out_valid, sum_out, carry_out, busy_out
    );
endinterface

// File: rtl/csa_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// csa_seq_adder_ctrl
// Purpose : Adds two WIDTH-bit operands plus a carry-in using one shared 4-bit
//           carry-select adder slice, one nibble per cycle, LSB nibble first.
//           The slice carry is chained between cycles through a register.
// Ports   :
//   clk    - clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - slave side of csa_seq_adder_ctrl_if (operand handshake, result
//            handshake, sum/carry and busy flag)
// Timing  : accept at edge E, out_valid high from edge E+NSLICE until the
//           result handshake; back-to-back initiation interval NSLICE+2.
// -----------------------------------------------------------------------------
module csa_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csa_seq_adder_ctrl_if.slave   bus
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 4-bit carry-select adder: both carry-in hypotheses are precomputed and
    // the real carry only drives the final select. Returns {carry, sum}.
    function automatic logic [4:0] csa_add4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [4:0] sum_c0;
        logic [4:0] sum_c1;
        sum_c0 = {1'b0, a} + {1'b0, b};
        sum_c1 = {1'b0, a} + {1'b0, b} + 5'd1;
        return cin ? sum_c1 : sum_c0;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_carry_out;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_accept;
    logic             w_last;
    logic [4:0]       w_slice;

    // Single shared slice: always fed from the low nibbles and the chained carry
    assign w_slice = csa_add4(r_a_sh[3:0], r_b_sh[3:0], r_carry);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum_out   = r_sum_out;
    assign bus.carry_out = r_carry_out;
    assign bus.busy_out  = r_busy;

    // Next-state logic; the handshake flags are registered from the next state
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ADD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ADD;
                end
            end
            ST_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_ADD) || (w_state_nxt == ST_DONE);
        end
    end

    // Operand capture, nibble-serial datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum_out   <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= bus.a_in;
                        r_b_sh  <= bus.b_in;
                        r_carry <= bus.c_in;
                        r_idx   <= '0;
                    end
                end
                ST_ADD: begin
                    // Constant-index loop keeps the nibble write a plain mux
                    for (int s = 0; s < NSLICE; s++) begin
                        if (int'(r_idx) == s) begin
                            r_sum_out[4*s +: 4] <= w_slice[3:0];
                        end
                    end
                    r_carry <= w_slice[4];
                    r_a_sh  <= r_a_sh >> 4'd4;
                    r_b_sh  <= r_b_sh >> 4'd4;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_carry_out <= w_slice[4];
                    end
                end
                ST_DONE: begin
                    // Result held stable for the consumer
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule
